// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one frame-timed UART transmitter.
// Ports: req/req_data in, grant/done/send_data/busy/tx_data out.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 288,
  parameter int BIT_CLKS   = 8,
  parameter int FRAME_BITS = 360,
  parameter int GAP_CLKS   = 16
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      send_data,
  output logic                      busy
);

  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;
  localparam int CW = $clog2(FRAME_CLKS + 1);
  localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam int GAP_LD = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]       gcnt_q, gcnt_d;
  logic [NUM_REQ-1:0]  grant_d, done_d;
  logic [DATA_W-1:0]   tx_d;
  logic                send_d, busy_d;
  logic [PW-1:0]       win, idx;
  logic                hit;
  logic [DATA_W-1:0]   slice [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign slice[k] = req_data[k*DATA_W +: DATA_W];
  end

  // Walk from farthest to nearest so the nearest set bit
  // after the last owner wins.
  always_comb begin
    win = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = PW'((int'(owner_q) + i) % NUM_REQ);
      if (req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    tx_d    = tx_data;
    grant_d = '0;
    done_d  = '0;
    send_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          owner_d = win;
          tx_d    = slice[win];
          grant_d = NUM_REQ'(1) << win;
          send_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = CW'(FRAME_CLKS - 1);
        state_d = SEND;
        if (FRAME_CLKS == 1) begin
          done_d = NUM_REQ'(1) << owner_q;
        end
      end
      SEND: begin
        if (cnt_q == '0) begin
          if (GAP_CLKS == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gcnt_d  = GW'(GAP_LD);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          // done is registered, so raise it one cycle early
          if (cnt_q == CW'(1)) begin
            done_d = NUM_REQ'(1) << owner_q;
          end
        end
      end
      GAP: begin
        if (gcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      owner_q   <= PW'(NUM_REQ - 1);
      cnt_q     <= '0;
      gcnt_q    <= '0;
      grant     <= '0;
      done      <= '0;
      send_data <= 1'b0;
      busy      <= 1'b0;
      tx_data   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      gcnt_q    <= gcnt_d;
      grant     <= grant_d;
      done      <= done_d;
      send_data <= send_d;
      busy      <= busy_d;
      tx_data   <= tx_d;
    end
  end

endmodule
